uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequencer between the UART receiver and the host side. Detects rdrf and captures {FE, rx_data} into an
//  internal FIFO. Acknowledges the receiver by pulsing rdrf_clr low. Presents bytes through a valid/ready port.
//  Flags overrun when a byte arrives with the FIFO full.
// PARAMETERS
//  DEPTH    8  FIFO entries; power of two, 2..64
//  AW       3  FIFO address width, log2(DEPTH)
//  ACK_TO   4  cycles to wait in WAIT_LOW for rdrf to fall before re-pulsing rdrf_clr; 1..255
// PORTS
//  clk        in   1  system clock, rising edge
//  clr        in   1  synchronous reset, active-high
//  rdrf       in   1  receiver data-ready flag
//  rx_data    in   8  receiver byte; valid while rdrf=1
//  FE         in   1  receiver framing error; valid while rdrf=1
//  rdrf_clr   out  1  receiver acknowledge, active-low; idles high
//  dout       out  8  head-of-FIFO byte
//  dout_fe    out  1  framing-error bit stored with dout
//  dout_valid out  1  FIFO not empty
//  dout_ready in   1  host pop; a pop happens when dout_valid & dout_ready
//  count      out  AW+1  FIFO occupancy, 0..DEPTH
//  full       out  1  count==DEPTH
//  ovr        out  1  sticky overrun flag
//  ovr_clr    in   1  clears ovr (and fe_count when UART_RX_ERRCNT_EN is defined)
//  fe_count   out  8  saturating framing-error count
// BEHAVIOUR
//  Clock and reset: one clock clk. clr is synchronous and active-high.
//  Reset values: rdrf_clr=1, dout_valid=0, count=0, full=0, ovr=0, fe_count=0, FSM=IDLE. dout and dout_fe are don't-care.
//  Reset mid-operation: any FSM state or FIFO contents are discarded; no rdrf_clr pulse is issued.
//  FSM states: IDLE, CAPTURE, ACK, WAIT_LOW.
//   IDLE:     rdrf=1 -> CAPTURE.
//   CAPTURE:  push {FE,rx_data} if (!full | pop this cycle); else drop the byte and set ovr. Then -> ACK.
//   ACK:      rdrf_clr=0 for exactly this one cycle; load timeout counter with ACK_TO; -> WAIT_LOW.
//   WAIT_LOW: rdrf=0 -> IDLE. If the timer expires with rdrf still 1 -> ACK (re-pulse). No second capture.
//  Latency: rdrf rises at cycle N -> FIFO write at N+1 -> rdrf_clr low at N+2 -> dout_valid visible at N+2.
//  FIFO: first-word fall-through; dout/dout_fe show the head entry whenever dout_valid=1.
//   Pop on empty is ignored.
//   Push and pop in the same cycle when full: both happen, count stays DEPTH, no overrun.
//   Push and pop in the same cycle when empty: count goes 0->1; the pushed entry becomes the head.
//   Pointers are AW bits and wrap modulo DEPTH; count is AW+1 bits and never wraps.
//  ovr: set in CAPTURE on a drop. ovr_clr in the same cycle as a drop -> the set wins (ovr stays 1).
//  Pushed FE bit is stored as received; entries with FE=1 are still delivered to the host.
// CONFIGURATION
//  Macro UART_RX_ERRCNT_EN.
//   Defined: fe_count increments on every CAPTURE with FE=1, including dropped bytes. Saturates at 8'hFF.
//            Cleared by ovr_clr; an increment in the same cycle as ovr_clr wins (result 1).
//   Undefined: fe_count is tied to 8'h00 and its counter logic is absent. Port list is unchanged.
// STRUCTURE
//  Package uart_pkg: FSM state encoding (IDLE=2'd0, CAPTURE=2'd1, ACK=2'd2, WAIT_LOW=2'd3),
//   FIFO entry width constant RX_ENT_W=9, and the default DEPTH.
//  Sub-module uart_rx_fifo (DEPTH, AW, width RX_ENT_W): storage, pointers, count, full/empty.
//   The FSM, ovr, fe_count and the rdrf_clr timing stay in uart_rx_ctrl.
// TESTING
//  1 Single byte: rdrf=1 with rx_data=8'hA5, FE=0, dout_ready=0
//    -> one rdrf_clr low pulse at N+2; dout=A5, dout_fe=0, count=1.
//  2 Fill: 9 bytes 8'h01..8'h09, dout_ready=0, DEPTH=8
//    -> full=1, ovr=1 after byte 9; pops then return 01..08 in order.
//  3 Full with pop: FIFO full, dout_ready=1 in the CAPTURE cycle of byte 8'h55
//    -> no ovr; 8'h55 lands at the tail; count stays 8.
//  4 Stuck rdrf: hold rdrf=1 for 12 cycles with ACK_TO=4
//    -> rdrf_clr pulses repeat every 5 cycles; exactly one FIFO entry is written.
//  5 Framing errors (macro defined): 3 bytes with FE=1 -> fe_count=3, all dout_fe=1.
//    Then ovr_clr=1 -> fe_count=0, ovr=0. Macro undefined -> fe_count stays 0.
//  6 Reset mid-frame: clr=1 during ACK
//    -> next cycle rdrf_clr=1, count=0, dout_valid=0, FSM=IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive sequencer: FSM state encoding,
// FIFO entry width and default FIFO depth.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    ACK      = 2'd2,
    WAIT_LOW = 2'd3
  } rx_state_e;

  // Each FIFO entry is {FE, rx_data}
  localparam int RX_ENT_W     = 9;
  localparam int RX_DEPTH_DEF = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO holding received {FE, byte} entries.
// A pop on empty is ignored; a push when full only succeeds together with a pop.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 9
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state: pointers and count, cleared by reset
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer between a UART receiver and the host. Captures {FE, rx_data}
// on rdrf into a FIFO, acknowledges with a one-cycle active-low rdrf_clr
// pulse (re-pulsed if rdrf stays high for ACK_TO cycles), presents bytes
// on a valid/ready port and flags overrun.
// Optional feature macro: UART_RX_ERRCNT_EN enables the saturating
// framing-error counter on fe_count; otherwise fe_count is tied to zero.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH  = RX_DEPTH_DEF,
  parameter int AW     = 3,
  parameter int ACK_TO = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          rdrf,
  input  logic [7:0]    rx_data,
  input  logic          FE,
  output logic          rdrf_clr,
  output logic [7:0]    dout,
  output logic          dout_fe,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          ovr,
  input  logic          ovr_clr,
  output logic [7:0]    fe_count
);

  localparam logic [7:0] ACK_TO_8 = 8'(ACK_TO);

  rx_state_e             state_q;
  logic [7:0]            timer_q;
  logic                  rdrf_clr_q;
  logic                  ovr_q;
  logic                  capture;
  logic                  pop;
  logic                  drop;
  logic                  fifo_empty;
  logic [RX_ENT_W-1:0]   fifo_rdata;

  assign capture = (state_q == CAPTURE);
  assign pop     = dout_valid & dout_ready;
  // A full FIFO still accepts the byte when the host frees a slot this cycle
  assign drop    = capture & full & ~pop;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (RX_ENT_W)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (capture),
    .wdata ({FE, rx_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  // Receiver handshake FSM with registered active-low acknowledge
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      rdrf_clr_q <= 1'b1;
    end else begin
      rdrf_clr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (rdrf) state_q <= CAPTURE;
        end
        CAPTURE: begin
          state_q    <= ACK;
          rdrf_clr_q <= 1'b0;
        end
        ACK: begin
          timer_q <= ACK_TO_8;
          state_q <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!rdrf) begin
            state_q <= IDLE;
          end else if (timer_q <= 8'd1) begin
            state_q    <= ACK;
            rdrf_clr_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky overrun: a drop outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (clr)          ovr_q <= 1'b0;
    else if (drop)    ovr_q <= 1'b1;
    else if (ovr_clr) ovr_q <= 1'b0;
  end

`ifdef UART_RX_ERRCNT_EN
  logic [7:0] fe_cnt_q;
  logic       fe_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign fe_inc = capture & FE;

  // Framing-error counter; counts dropped bytes too, increment beats clear
  always_ff @(posedge clk) begin
    if (clr)          fe_cnt_q <= '0;
    else if (fe_inc)  fe_cnt_q <= ovr_clr ? 8'd1 : sat_inc8(fe_cnt_q);
    else if (ovr_clr) fe_cnt_q <= '0;
  end

  assign fe_count = fe_cnt_q;
`else
  assign fe_count = 8'h00;
`endif

  assign rdrf_clr   = rdrf_clr_q;
  assign ovr        = ovr_q;
  assign dout_valid = ~fifo_empty;
  assign dout       = fifo_rdata[7:0];
  assign dout_fe    = fifo_rdata[8];

endmodule
